// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared MIPS encoding constants for the single-cycle core and its program
// loader. The main opcode decoder and the instruction encoder both import
// this package so opcode/funct values live in exactly one place.
//
// Contents:
//   OP_*        6-bit primary opcodes of the supported instruction subset
//   F_*         6-bit funct codes for R-type ALU operations
//   kind_t      symbolic instruction kind presented to the loader
//   load_state_t  loader FSM states
//   helpers     field packers for the I-type / J-type / R-type formats
// ---------------------------------------------------------------------------
package mips_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    // Symbolic instruction kinds; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        KIND_RTYPE = 3'd0,
        KIND_LW    = 3'd1,
        KIND_SW    = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ADDI  = 3'd4,
        KIND_J     = 3'd5
    } kind_t;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

    // I-type: {op, rs, rt, imm}
    function automatic logic [31:0] pack_itype(input logic [5:0]  op,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rt,
                                               input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // R-type: {000000, rs, rt, rd, shamt=0, funct}
    function automatic logic [31:0] pack_rtype(input logic [4:0] rs,
                                               input logic [4:0] rt,
                                               input logic [4:0] rd,
                                               input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    // J-type: {op, target}
    function automatic logic [31:0] pack_jtype(input logic [5:0]  op,
                                               input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_encode.sv
// ---------------------------------------------------------------------------
// instr_encode
// Purely combinational MIPS instruction encoder: the inverse of the main
// opcode decoder. Fields that a given kind does not use are ignored; shamt
// is always encoded as zero.
//
// Ports:
//   kind    in  3   symbolic instruction kind (see mips_pkg::kind_t)
//   rs      in  5   rs register field
//   rt      in  5   rt register field
//   rd      in  5   rd register field (R-type only)
//   funct   in  6   funct field (R-type only)
//   imm     in  16  immediate / branch offset, passed through raw
//   target  in  26  jump target field (J only)
//   word    out 32  encoded machine word (0 when illegal)
//   illegal out 1   kind is not one of the six supported kinds
// ---------------------------------------------------------------------------
module instr_encode
    import mips_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (kind)
            KIND_RTYPE: word = pack_rtype(rs, rt, rd, funct);
            KIND_LW:    word = pack_itype(OP_LW,   rs, rt, imm);
            KIND_SW:    word = pack_itype(OP_SW,   rs, rt, imm);
            KIND_BEQ:   word = pack_itype(OP_BEQ,  rs, rt, imm);
            KIND_ADDI:  word = pack_itype(OP_ADDI, rs, rt, imm);
            KIND_J:     word = pack_jtype(OP_J, target);
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
// Accepts symbolic instructions over a valid/ready stream, encodes each into
// a 32-bit MIPS word and writes the words to consecutive imem addresses
// starting at 0. Used by the boot path and test harness to load programs.
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready
// are both high. in_ready depends only on registered state, never on
// in_valid, so the source may hold in_valid high and stream one word per
// cycle. Once offered, the source keeps the fields stable until accepted.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   start          pulse; begins a load at word 0 (ignored while loading)
//   in_valid/in_ready/in_last   input stream handshake + end-of-program mark
//   in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target  fields
//   imem_we, imem_waddr, imem_wdata   single imem write port (1-cycle pulse)
//   busy           FSM is in LOAD
//   done           load finished; held until next start
//   full           DEPTH words written
//   err            sticky; an illegal kind was consumed this load
//   words          number of words written this load
// ---------------------------------------------------------------------------
module instr_encoder_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [2:0]    in_kind,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [5:0]    in_funct,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic          err,
    output logic [AW:0]   words
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    load_state_t   state_q, state_d;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   words_q;
    logic          err_q, done_q, full_q;
    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [31:0]   wdata_q;

    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic          accept;
    logic          load_start;
    logic [AW:0]   words_inc;
    logic          hits_depth;

    instr_encode u_encode (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .funct   (in_funct),
        .imm     (in_imm),
        .target  (in_target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign accept     = in_valid && in_ready;
    assign load_start = start && (state_q != ST_LOAD);
    assign words_inc  = words_q + (AW+1)'(1);
    // Only a legal word advances the count, so only it can fill the memory.
    assign hits_depth = !enc_illegal && (words_inc == DEPTH_W);

    // -----------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            // in_last and reaching DEPTH on the same word is one transition.
            ST_LOAD: if (accept && (in_last || hits_depth)) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------
    // FSM: outputs (from registered state only)
    // -----------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = !full_q;
                busy     = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------
    // Datapath: pointer, counters, sticky flags, write-port registers.
    // The write appears the cycle after the accept; done is raised on the
    // same edge so the final imem_we and done=1 coincide.
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'h0000_0000;
        end else begin
            we_q <= 1'b0;
            if (load_start) begin
                ptr_q   <= '0;
                words_q <= '0;
                err_q   <= 1'b0;
                done_q  <= 1'b0;
                full_q  <= 1'b0;
            end else if (accept) begin
                if (enc_illegal) begin
                    // Consumed with no write; address space is not advanced.
                    err_q <= 1'b1;
                end else begin
                    we_q    <= 1'b1;
                    waddr_q <= ptr_q;
                    wdata_q <= enc_word;
                    ptr_q   <= ptr_q + AW'(1);
                    words_q <= words_inc;
                    if (hits_depth) full_q <= 1'b1;
                end
                if (in_last || hits_depth) done_q <= 1'b1;
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign done       = done_q;
    assign full       = full_q;
    assign err        = err_q;
    assign words      = words_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder_loader
// Directed bench for instr_encoder_loader. Two instances share one input
// stream: u_dut (DEPTH=64) and u_dut4 (DEPTH=4) for the capacity case.
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        in_ready;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        busy, done, full, err;
    logic [6:0]  words;

    logic        in_ready_4;
    logic        imem_we_4;
    logic [1:0]  imem_waddr_4;
    logic [31:0] imem_wdata_4;
    logic        busy_4, done_4, full_4, err_4;
    logic [2:0]  words_4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.DEPTH(64), .AW(6)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_funct   (in_funct),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .full       (full),
        .err        (err),
        .words      (words)
    );

    instr_encoder_loader #(.DEPTH(4), .AW(2)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready_4),
        .in_last    (in_last),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_funct   (in_funct),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .imem_we    (imem_we_4),
        .imem_waddr (imem_waddr_4),
        .imem_wdata (imem_wdata_4),
        .busy       (busy_4),
        .done       (done_4),
        .full       (full_4),
        .err        (err_4),
        .words      (words_4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                         input logic [25:0] tgt, input logic last);
        in_valid  = 1'b1;
        in_kind   = k;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_funct  = fn;
        in_imm    = imm;
        in_target = tgt;
        in_last   = last;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Six-word program: RTYPE, LW, SW, BEQ, J, ADDI(last)
    logic [2:0]  t_kind [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4};
    logic [4:0]  t_rs   [6] = '{5'd1, 5'd0, 5'd0, 5'd1, 5'd0, 5'd1};
    logic [4:0]  t_rt   [6] = '{5'd2, 5'd8, 5'd8, 5'd2, 5'd0, 5'd2};
    logic [4:0]  t_rd   [6] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [5:0]  t_fn   [6] = '{6'h20, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0};
    logic [15:0] t_imm  [6] = '{16'h0, 16'h4, 16'h8, 16'hFFFF, 16'h0, 16'h5};
    logic [25:0] t_tgt  [6] = '{26'h0, 26'h0, 26'h0, 26'h0, 26'h10, 26'h0};
    logic [31:0] t_exp  [6] = '{32'h00221820, 32'h8C080004, 32'hAC080008,
                                32'h1022FFFF, 32'h08000010, 32'h20220005};

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_kind = '0; in_rs = '0; in_rt = '0;
        in_rd = '0; in_funct = '0; in_imm = '0; in_target = '0;

        // ---- Reset values ----
        step();
        step();
        check("rst_we",    32'(imem_we),    32'h0);
        check("rst_waddr", 32'(imem_waddr), 32'h0);
        check("rst_wdata", imem_wdata,      32'h0);
        check("rst_ready", 32'(in_ready),   32'h0);
        check("rst_busy",  32'(busy),       32'h0);
        check("rst_done",  32'(done),       32'h0);
        check("rst_full",  32'(full),       32'h0);
        check("rst_err",   32'(err),        32'h0);
        check("rst_words", 32'(words),      32'h0);
        reset = 1'b0;
        step();
        check("idle_ready", 32'(in_ready), 32'h0);

        // ---- Single ADDI with in_last ----
        pulse_start();
        check("t1_busy",  32'(busy),     32'h1);
        check("t1_ready", 32'(in_ready), 32'h1);
        drive(3'd4, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b1);
        step();
        idle_in();
        check("t1_we",    32'(imem_we),    32'h1);
        check("t1_waddr", 32'(imem_waddr), 32'h0);
        check("t1_wdata", imem_wdata,      32'h20220005);
        check("t1_done",  32'(done),       32'h1);
        check("t1_words", 32'(words),      32'h1);
        check("t1_err",   32'(err),        32'h0);
        check("t1_busy",  32'(busy),       32'h0);
        step();
        check("t1_we_pulse", 32'(imem_we),    32'h0);
        check("t1_hold_wd",  imem_wdata,      32'h20220005);
        check("t1_done_hld", 32'(done),       32'h1);
        check("t1_ready_dn", 32'(in_ready),   32'h0);

        // ---- Six back-to-back words ----
        pulse_start();
        check("t2_done_clr", 32'(done), 32'h0);
        for (int i = 0; i < 6; i++) begin
            drive(t_kind[i], t_rs[i], t_rt[i], t_rd[i], t_fn[i], t_imm[i], t_tgt[i], i == 5);
            step();
            check($sformatf("t2_we%0d", i),    32'(imem_we),    32'h1);
            check($sformatf("t2_waddr%0d", i), 32'(imem_waddr), 32'(i));
            check($sformatf("t2_wdata%0d", i), imem_wdata,      t_exp[i]);
            check($sformatf("t2_done%0d", i),  32'(done),       32'(i == 5));
        end
        idle_in();
        check("t2_words", 32'(words), 32'd6);
        step();
        check("t2_we_end", 32'(imem_we), 32'h0);

        // ---- Illegal kind mid-stream ----
        pulse_start();
        drive(3'd1, 5'd0, 5'd8, 5'd0, 6'h0, 16'h4, 26'h0, 1'b0);
        step();
        check("t3_we0",    32'(imem_we),    32'h1);
        check("t3_waddr0", 32'(imem_waddr), 32'h0);
        check("t3_wdata0", imem_wdata,      32'h8C080004);
        drive(3'd7, 5'd3, 5'd3, 5'd3, 6'h3, 16'h3, 26'h3, 1'b0);
        step();
        check("t3_we_ill",  32'(imem_we), 32'h0);
        check("t3_err_ill", 32'(err),     32'h1);
        check("t3_words1",  32'(words),   32'h1);
        drive(3'd2, 5'd0, 5'd8, 5'd0, 6'h0, 16'h8, 26'h0, 1'b1);
        step();
        idle_in();
        check("t3_we1",    32'(imem_we),    32'h1);
        check("t3_waddr1", 32'(imem_waddr), 32'h1);
        check("t3_wdata1", imem_wdata,      32'hAC080008);
        check("t3_err",    32'(err),        32'h1);
        check("t3_words",  32'(words),      32'h2);
        check("t3_done",   32'(done),       32'h1);

        // ---- Capacity (DEPTH=4 instance): 5 words, no in_last ----
        step();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            drive(3'd4, 5'd1, 5'd2, 5'd0, 6'h0, 16'(i), 26'h0, 1'b0);
            step();
            check($sformatf("t4_we%0d", i),    32'(imem_we_4),    32'h1);
            check($sformatf("t4_waddr%0d", i), 32'(imem_waddr_4), 32'(i));
            check($sformatf("t4_wdata%0d", i), imem_wdata_4,      32'h20220000 + 32'(i));
            check($sformatf("t4_full%0d", i),  32'(full_4),       32'(i == 3));
        end
        check("t4_done",  32'(done_4),     32'h1);
        check("t4_ready", 32'(in_ready_4), 32'h0);
        drive(3'd4, 5'd1, 5'd2, 5'd0, 6'h0, 16'h4, 26'h0, 1'b0);
        step();
        idle_in();
        check("t4_no5th",  32'(imem_we_4),    32'h0);
        check("t4_words",  32'(words_4),      32'h4);
        check("t4_waddr",  32'(imem_waddr_4), 32'h3);
        check("t4_full_h", 32'(full_4),       32'h1);

        // The 64-deep instance is still mid-load; bring both back to IDLE.
        reset = 1'b1;
        step();
        reset = 1'b0;

        // ---- Back-pressure: in_valid 1,0,1 ----
        pulse_start();
        drive(3'd4, 5'd1, 5'd2, 5'd0, 6'h0, 16'h1, 26'h0, 1'b0);
        step();
        idle_in();
        check("t5_we0",    32'(imem_we),    32'h1);
        check("t5_waddr0", 32'(imem_waddr), 32'h0);
        check("t5_wdata0", imem_wdata,      32'h20220001);
        step();
        check("t5_gap_we",    32'(imem_we),    32'h0);
        check("t5_gap_waddr", 32'(imem_waddr), 32'h0);
        check("t5_gap_words", 32'(words),      32'h1);
        drive(3'd4, 5'd1, 5'd2, 5'd0, 6'h0, 16'h3, 26'h0, 1'b1);
        step();
        idle_in();
        check("t5_we1",    32'(imem_we),    32'h1);
        check("t5_waddr1", 32'(imem_waddr), 32'h1);
        check("t5_wdata1", imem_wdata,      32'h20220003);
        check("t5_words",  32'(words),      32'h2);
        check("t5_done",   32'(done),       32'h1);

        // ---- Reset right after an accept ----
        step();
        pulse_start();
        drive(3'd6, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
        step();
        check("t6_err_set", 32'(err), 32'h1);
        drive(3'd4, 5'd1, 5'd2, 5'd0, 6'h0, 16'h7, 26'h0, 1'b0);
        step();
        idle_in();
        check("t6_we_pre", 32'(imem_we), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_we",    32'(imem_we),    32'h0);
        check("t6_waddr", 32'(imem_waddr), 32'h0);
        check("t6_wdata", imem_wdata,      32'h0);
        check("t6_busy",  32'(busy),       32'h0);
        check("t6_err",   32'(err),        32'h0);
        check("t6_words", 32'(words),      32'h0);
        check("t6_done",  32'(done),       32'h0);
        pulse_start();
        check("t6_busy2", 32'(busy), 32'h1);
        drive(3'd1, 5'd0, 5'd8, 5'd0, 6'h0, 16'h4, 26'h0, 1'b1);
        step();
        idle_in();
        check("t6_re_we",    32'(imem_we),    32'h1);
        check("t6_re_waddr", 32'(imem_waddr), 32'h0);
        check("t6_re_wdata", imem_wdata,      32'h8C080004);
        check("t6_re_err",   32'(err),        32'h0);
        check("t6_re_words", 32'(words),      32'h1);
        check("t6_re_done",  32'(done),       32'h1);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the main opcode decoder. Accepts a stream of symbolic instructions (kind plus fields) over a valid/ready handshake and encodes each into a 32-bit MIPS machine word. Writes the words sequentially into instruction memory through a single write port. Used by the test harness and boot path to load programs for the single-cycle core.

Parameters:
DEPTH, 64, imem capacity in words; loading stops when reached.
AW, 6, imem word-address width (clog2(DEPTH)).

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a load at word 0 (honoured in IDLE/DONE only)
in_valid  in  1  source has an instruction
in_ready  out  1  block can accept this cycle
in_last  in  1  marks final instruction of the program
in_kind  in  3  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6-7 illegal
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_funct  in  6  funct field
in_imm  in  16  immediate / branch offset, raw
in_target  in  26  jump target field
imem_we  out  1  imem write strobe
imem_waddr  out  AW  imem word address
imem_wdata  out  32  encoded word
busy  out  1  state == LOAD
done  out  1  load finished; held until next start
full  out  1  words == DEPTH
err  out  1  sticky; an illegal kind was consumed during this load
words  out  AW+1  count of words written this load

Behaviour:
- Reset values: state IDLE; imem_we, imem_waddr, imem_wdata, in_ready, busy, done, full, err, words all 0. Any accepted-but-unwritten word is dropped.
- Encoding (shamt always 0; unused fields ignored):
  - RTYPE: {000000, rs, rt, rd, 00000, funct}
  - LW: {100011, rs, rt, imm}
  - SW: {101011, rs, rt, imm}
  - BEQ: {000100, rs, rt, imm}
  - ADDI: {001000, rs, rt, imm}
  - J: {000010, target}
- FSM states IDLE, LOAD, DONE.
- IDLE: in_ready=0. If start=1, next state is LOAD and ptr, words, err, done, full are cleared.
- LOAD:
  - in_ready = !full (combinational from registered state).
  - Accept when in_valid && in_ready.
  - Legal accept: next cycle imem_we=1, imem_waddr=ptr, imem_wdata=encoded word. ptr and words increment on that same edge. Latency is 1 cycle; throughput is 1 word per cycle.
  - Illegal accept (kind 6/7): consumed with no write; err<=1; ptr and words unchanged.
  - start is ignored.
- LOAD -> DONE on the edge after accepting in_last=1 (legal or illegal), or after accepting the word that makes words == DEPTH. The final write's imem_we and done=1 appear in the same cycle.
- Full condition: full=1, in_ready=0, no further accepts; further in_valid is ignored.
- DONE: in_ready=0, done=1, imem_we=0 after the final write; words and err hold. start -> LOAD with clears as in IDLE.
- imem_we is a single-cycle pulse per word. imem_waddr and imem_wdata hold their last values when imem_we=0.
- Simultaneous events: reset has priority over everything. Accepting a word with in_last=1 and reaching DEPTH on the same word gives one transition to DONE.

Decomposition:
- Shared package mips_pkg holds opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), the kind enum, and funct constants (F_ADD=100000, etc.). The existing main decoder should use the same opcode constants.
- One sub-module, instr_encode: combinational (kind, rs, rt, rd, funct, imm, target) -> (word[31:0], illegal). It mirrors the decoder and can be tested standalone.
- The top level holds the FSM, pointer, counters and output registers.

Test Plan:
- Reset, start, ADDI rs=1 rt=2 imm=0x0005 with in_last -> next cycle imem_we=1, waddr=0, wdata=0x20220005, done=1, words=1, err=0.
- Stream of 6 back-to-back words, in_valid held high: RTYPE rs1 rt2 rd3 funct 0x20; LW rs0 rt8 imm4; SW rs0 rt8 imm8; BEQ rs1 rt2 imm 0xFFFF; J target 0x10; ADDI as above with in_last. Required writes on consecutive cycles: waddr 0..5 with wdata 0x00221820, 0x8C080004, 0xAC080008, 0x1022FFFF, 0x08000010, 0x20220005; words=6.
- Illegal mid-stream: LW, kind=7, SW with in_last -> exactly 2 writes at waddr 0,1; err=1; words=2; done=1.
- DEPTH=4, send 5 valid words with no in_last -> 4 writes; full=1, done=1, in_ready=0; 5th word never accepted.
- Back-pressure: in_valid toggles 1,0,1 -> imem_we pulses only on the cycles after accepts; waddr increments only per write.
- Reset asserted the cycle after an accept in LOAD -> imem_we=0 next cycle, all outputs 0; a new start reloads from waddr 0 with err and words cleared.
